pipe_stage_skid_buf: RTL

- Parametrised successor to the fixed MEM/WB-style pipeline register.
- Carries a control field plus LANES data words between two pipeline stages.
- Replaces the global stall wire with a per-stage valid/ready handshake.
- A 2-entry skid buffer keeps in_ready fully registered, so no combinational path runs from out_ready to in_ready.
- flush inserts a bubble: control is zeroed, so write-enables in the control field are deasserted. Any inter-stage boundary can instantiate it (IF/ID through MEM/WB).

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/pipe_entry_reg.sv | 56 +++++
 rtl/pipe_stage_skid_buf.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, the MEM/WB control-field layout and the occupancy decode
// used by every pipeline stage register.
package pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 8;
  localparam int unsigned PIPE_DATA_W = 16;
  localparam int unsigned PIPE_LANES  = 2;

  // MSB first: {regdst, regwrite, memtoreg[1:0], reg_source[3:0]}
  typedef struct packed {
    logic       regdst;
    logic       regwrite;
    logic [1:0] memtoreg;
    logic [3:0] reg_source;
  } memwb_ctrl_t;

  localparam int unsigned MEMWB_CTRL_W = $bits(memwb_ctrl_t);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull,
    StBad
  } occ_state_e;

  // Skid valid without main valid is unreachable; it decodes to StBad.
  function automatic occ_state_e occ_state(input logic m_v, input logic s_v);
    unique case ({m_v, s_v})
      2'b00:   return StEmpty;
      2'b10:   return StOne;
      2'b11:   return StFull;
      default: return StBad;
    endcase
  endfunction

  function automatic logic [MEMWB_CTRL_W-1:0] pack_memwb(input memwb_ctrl_t c);
    return c;
  endfunction

  function automatic memwb_ctrl_t unpack_memwb(input logic [MEMWB_CTRL_W-1:0] raw);
    return memwb_ctrl_t'(raw);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry (valid + control + data) with load, clear and
// drop controls. Drop only retires the valid bit; the payload stays put.
module pipe_entry_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid_buf.sv
// Valid/ready pipeline stage with a 2-entry skid buffer so in_ready is a
// pure register output; flush turns the stage into a bubble.
module pipe_stage_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned LANES  = PIPE_LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy
);

  localparam int unsigned PayW = LANES * DATA_W;

  logic              m_v, s_v;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [PayW-1:0]   m_data, s_data;

  logic              acc, pop;
  occ_state_e        state;
  logic              m_load, m_drop, m_from_skid, s_load, s_drop;
  logic [CTRL_W-1:0] m_ctrl_in;
  logic [PayW-1:0]   m_data_in;

  assign acc   = in_valid & ~s_v;
  assign pop   = m_v & out_ready;
  assign state = occ_state(m_v, s_v);

  always_comb begin
    m_load      = 1'b0;
    m_drop      = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    s_drop      = 1'b0;
    if (!flush) begin
      unique case (state)
        StEmpty: m_load = acc;
        StOne: begin
          if (pop && acc) begin
            m_load = 1'b1;
          end else if (pop) begin
            m_drop = 1'b1;
          end else if (acc) begin
            s_load = 1'b1;
          end
        end
        StFull: begin
          // Skid only ever promotes into main, preserving FIFO order.
          if (pop) begin
            m_load      = 1'b1;
            m_from_skid = 1'b1;
            s_drop      = 1'b1;
          end
        end
        default: begin
          m_drop = 1'b1;
          s_drop = 1'b1;
        end
      endcase
    end
  end

  assign m_ctrl_in = m_from_skid ? s_ctrl : in_ctrl;
  assign m_data_in = m_from_skid ? s_data : in_data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (PayW)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .load_i  (m_load),
    .drop_i  (m_drop),
    .ctrl_i  (m_ctrl_in),
    .data_i  (m_data_in),
    .valid_o (m_v),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (PayW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .load_i  (s_load),
    .drop_i  (s_drop),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (s_v),
    .ctrl_o  (s_ctrl),
    .data_o  (s_data)
  );

  assign out_valid = m_v;
  assign out_ctrl  = m_v ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_v} + {1'b0, s_v};
  assign in_ready  = ~s_v;

  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) !(s_v && !m_v));

endmodule
